// File: rtl/seg7_display_monitor.sv
// Receive-side monitor for a two-digit active-low seven-segment countdown display.
// Decodes each ticked sample to a count and checks it follows the legal count sequence.
module seg7_display_monitor #(
    parameter int WIDTH     = 5,
    parameter int MAX_VALUE = 31,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [6:0]       seg_ones,
    input  logic [6:0]       seg_tens,
    input  logic             dir_down,
    input  logic             pause,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             seg_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {SYNC, TRACK} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               value_valid_q, value_valid_d;
    logic               seg_err_q, seg_err_d;
    logic               seq_err_q, seq_err_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic [4:0]         ones_dec, tens_dec;
    logic [6:0]         candidate;
    logic               legal;
    logic [WIDTH-1:0]   expected;

    // Returns {ok, digit}; blank is legal only on the tens digit (leading-zero blanking).
    function automatic logic [4:0] decode_digit(input logic [6:0] seg, input logic blank_ok);
        case (seg)
            7'h40:   return {1'b1, 4'd0};
            7'h79:   return {1'b1, 4'd1};
            7'h24:   return {1'b1, 4'd2};
            7'h30:   return {1'b1, 4'd3};
            7'h19:   return {1'b1, 4'd4};
            7'h12:   return {1'b1, 4'd5};
            7'h02:   return {1'b1, 4'd6};
            7'h78:   return {1'b1, 4'd7};
            7'h00:   return {1'b1, 4'd8};
            7'h10:   return {1'b1, 4'd9};
            7'h7F:   return {blank_ok, 4'd0};
            default: return 5'd0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        seg_err_d     = 1'b0;
        seq_err_d     = 1'b0;
        err_count_d   = err_count_q;

        ones_dec  = decode_digit(seg_ones, 1'b0);
        tens_dec  = decode_digit(seg_tens, 1'b1);
        candidate = 7'(tens_dec[3:0]) * 7'd10 + 7'(ones_dec[3:0]);
        legal     = ones_dec[4] && tens_dec[4] && (candidate <= 7'(MAX_VALUE));

        // The stored value doubles as the reference for the successor check.
        if (pause)
            expected = value_q;
        else if (dir_down)
            expected = (value_q == '0) ? WIDTH'(MAX_VALUE) : value_q - WIDTH'(1);
        else
            expected = (value_q == WIDTH'(MAX_VALUE)) ? '0 : value_q + WIDTH'(1);

        if (tick) begin
            if (!legal) begin
                seg_err_d = 1'b1;
                state_d   = SYNC;
                if (err_count_q != '1)
                    err_count_d = err_count_q + ERR_W'(1);
            end else begin
                value_d       = WIDTH'(candidate);
                value_valid_d = 1'b1;
                state_d       = TRACK;
                if (state_q == TRACK && WIDTH'(candidate) != expected) begin
                    seq_err_d = 1'b1;
                    if (err_count_q != '1)
                        err_count_d = err_count_q + ERR_W'(1);
                end
            end
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SYNC;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            seg_err_q     <= seg_err_d;
            seq_err_q     <= seq_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign seg_err     = seg_err_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == TRACK);
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_seg7_display_monitor.sv
// Bench for seg7_display_monitor: directed literal checks plus a randomized run scored
// against a count-level model; a second instance with ERR_W=2 exercises saturation.
module tb_seg7_display_monitor;

    localparam int MAXV = 31;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [6:0] seg_ones = 7'h7F;
    logic [6:0] seg_tens = 7'h7F;
    logic       dir_down = 1'b0;
    logic       pause = 1'b0;

    logic [4:0] value, value2;
    logic       value_valid, seg_err, seq_err, locked;
    logic       value_valid2, seg_err2, seq_err2, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    bit [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_display_monitor #(.WIDTH(5), .MAX_VALUE(MAXV), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .seg_ones(seg_ones), .seg_tens(seg_tens),
        .dir_down(dir_down), .pause(pause), .value(value), .value_valid(value_valid),
        .seg_err(seg_err), .seq_err(seq_err), .locked(locked), .err_count(err_count));

    seg7_display_monitor #(.WIDTH(5), .MAX_VALUE(MAXV), .ERR_W(2)) dut_sat (
        .clk(clk), .reset(reset), .tick(tick), .seg_ones(seg_ones), .seg_tens(seg_tens),
        .dir_down(dir_down), .pause(pause), .value(value2), .value_valid(value_valid2),
        .seg_err(seg_err2), .seq_err(seq_err2), .locked(locked2), .err_count(err_count2));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Count-level model of the monitor.
    bit m_locked = 0, e_vv = 0, e_seg = 0, e_seq = 0;
    int m_val = 0, m_err8 = 0, m_err2 = 0;

    function automatic int dec(bit [6:0] s, bit is_tens);
        if (is_tens && s == 7'h7F) return 0;
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic int succ(int r, bit dn, bit ps);
        if (ps) return r;
        return dn ? (r + MAXV) % (MAXV + 1) : (r + 1) % (MAXV + 1);
    endfunction

    always @(posedge clk or negedge reset) begin
        int t, o, c;
        if (!reset) begin
            m_locked = 0; m_val = 0; m_err8 = 0; m_err2 = 0;
            e_vv = 0; e_seg = 0; e_seq = 0;
        end else begin
            e_vv = 0; e_seg = 0; e_seq = 0;
            if (tick) begin
                t = dec(seg_tens, 1'b1);
                o = dec(seg_ones, 1'b0);
                c = t * 10 + o;
                if (t < 0 || o < 0 || c > MAXV) begin
                    e_seg = 1; m_locked = 0;
                end else begin
                    if (m_locked && c != succ(m_val, dir_down, pause)) e_seq = 1;
                    m_val = c; e_vv = 1; m_locked = 1;
                end
                if (e_seg || e_seq) begin
                    m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
                    m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (check_en) begin
            check("value", value, m_val);
            check("value_valid", value_valid, e_vv);
            check("seg_err", seg_err, e_seg);
            check("seq_err", seq_err, e_seq);
            check("locked", locked, m_locked);
            check("err_count", err_count, m_err8);
            check("err_count_sat", err_count2, m_err2);
        end
    end

    task automatic present(input int n);
        seg_tens = (n / 10 == 0) ? 7'h7F : seg_tab[n / 10];
        seg_ones = seg_tab[n % 10];
    endtask

    // Entered and left on a falling edge; outputs for the tick are visible on return.
    task automatic tick_raw(input bit [6:0] t, input bit [6:0] o);
        seg_tens = t; seg_ones = o; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic tick_num(input int n);
        present(n); tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int r, kind, n;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("rst_value", value, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err_count, 0);
        reset = 1'b1;

        tick_raw(7'h7F, 7'h30);
        check("first_value", value, 3);
        check("first_valid", value_valid, 1);
        check("first_locked", locked, 1);
        check("first_err", err_count, 0);

        dir_down = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick_num(i);
            check("down_value", value, i);
            check("down_seq", seq_err, 0);
        end
        tick_raw(7'h24, 7'h79);
        check("jump_seq", seq_err, 1);
        check("jump_value", value, 21);
        check("jump_err", err_count, 1);
        check("jump_locked", locked, 1);

        for (int i = 20; i >= 0; i--) tick_num(i);
        tick_raw(7'h30, 7'h79);
        check("wrap_down_value", value, 31);
        check("wrap_down_err", seq_err | seg_err, 0);
        dir_down = 1'b0;
        tick_raw(7'h7F, 7'h40);
        check("wrap_up_value", value, 0);
        check("wrap_up_err", seq_err | seg_err, 0);
        for (int i = 1; i <= 17; i++) tick_num(i);

        pause = 1'b1;
        repeat (2) begin
            tick_num(17);
            check("pause_hold_seq", seq_err, 0);
        end
        dir_down = 1'b1;
        tick_num(16);
        check("pause_prio_seq", seq_err, 1);
        check("pause_prio_err", err_count, 2);
        pause = 1'b0;

        tick_raw(7'h79, 7'h7F);
        check("blank_ones_seg", seg_err, 1);
        check("blank_ones_locked", locked, 0);
        check("blank_ones_value", value, 16);
        tick_raw(7'h30, 7'h24);
        check("range_seg", seg_err, 1);
        check("range_locked", locked, 0);
        tick_num(5);
        check("relock_locked", locked, 1);
        check("relock_seq", seq_err, 0);
        check("relock_value", value, 5);

        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick_raw(7'h7F, 7'h7F);
            check("sat_err2", err_count2, (i < 3) ? i : 3);
            check("sat_err8", err_count, i);
        end

        tick_num(7);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_value", value, 0);
        check("async_locked", locked, 0);
        check("async_err", err_count, 0);
        check("async_valid", value_valid, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(299) == 0) reset = 1'b0;
            else reset = 1'b1;
            tick     = ($urandom_range(99) < 70);
            dir_down = $urandom_range(1);
            pause    = ($urandom_range(3) == 0);
            kind     = $urandom_range(9);
            if (kind <= 4) present(succ(m_val, dir_down, pause));
            else if (kind <= 6) present($urandom_range(MAXV));
            else if (kind == 7) present($urandom_range(99));
            else if (kind == 8) begin
                r = $urandom;
                seg_tens = r[6:0];
                seg_ones = r[13:7];
            end else begin
                n = $urandom_range(MAXV);
                present(n);
                seg_ones = 7'h7F;
            end
            @(negedge clk);
        end
        reset = 1'b1;
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
